muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the MUL/DIV unit.
- Accepts a multiply or divide request from the control unit and iterates a shift-add multiplier or restoring divider over WIDTH cycles.
- Drives the 2*WIDTH-bit input and write enable of the HI/LO register pair.
- HI = upper product / remainder; LO = lower product / quotient.

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 135 +++++++++++++
 tb/tb_muldiv_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the control unit (master) and the MUL/DIV sequencer (slave).
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic                 hilo_en;
    logic [2*WIDTH-1:0]   hilo_d;
    logic                 div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hilo_en, hilo_d, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hilo_en, hilo_d, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle shift-add multiplier / restoring divider driving the HI/LO register pair.
// Define MULDIV_SIGNED_EN to make op[1] select signed MUL/DIV; otherwise all ops are unsigned.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         clr,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StWb} state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic               bzero_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [2*WIDTH-1:0] hilo_q;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic               div_zero_keep;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

`ifdef MULDIV_SIGNED_EN
    assign signed_op = bus.op[1];
`else
    logic unused_op_msb;
    assign unused_op_msb = bus.op[1];
    assign signed_op     = 1'b0;
`endif

    // Operand conditioning at accept: magnitudes plus the signs to restore in FIX.
    always_comb begin
        a_neg         = signed_op & bus.a[WIDTH-1];
        b_neg         = signed_op & bus.b[WIDTH-1];
        b_zero        = (bus.b == '0);
        div_zero_keep = bus.op[0] & b_zero;
        // A zero-divisor divide keeps the raw dividend so the remainder reads back unchanged.
        a_mag         = (a_neg && !div_zero_keep) ? -bus.a : bus.a;
        b_mag         = b_neg ? -bus.b : bus.b;
    end

    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        trial    = rem_sh - {1'b0, opnd_q};
        div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        fix_hi   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_lo   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fix_res  = is_div_q ? {fix_hi, fix_lo} : (neg_lo_q ? -acc_q : acc_q);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            opnd_q     <= '0;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            bzero_q    <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hilo_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        // Multiply: acc low half holds the multiplier. Divide: holds the dividend.
                        acc_q    <= {{WIDTH{1'b0}}, bus.op[0] ? a_mag : b_mag};
                        opnd_q   <= bus.op[0] ? b_mag : a_mag;
                        is_div_q <= bus.op[0];
                        bzero_q  <= b_zero;
                        neg_lo_q <= (a_neg ^ b_neg) & ~div_zero_keep;
                        neg_hi_q <= a_neg & bus.op[0] & ~b_zero;
                        count_q  <= CW'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q   <= is_div_q ? div_next : mul_next;
                    count_q <= count_q - CW'(1);
                    if (count_q == '0) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hilo_q     <= fix_res;
                    done_q     <= 1'b1;
                    div_zero_q <= is_div_q & bzero_q;
                    state_q    <= StWb;
                end
                StWb: begin
                    done_q     <= 1'b0;
                    div_zero_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hilo_en  = done_q;
    assign bus.hilo_d   = hilo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    localparam int unsigned W = 32;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;
    int   n_wr;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (!clr && bus.hilo_en) n_wr++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Plain-arithmetic reference: {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint    sa, sb, q, r;
        bit        sgn;
`ifdef MULDIV_SIGNED_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[0]) return 64'(sa * sb);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        int          busy_n;
        bit          seen;
        exp = model(op, a, b);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        busy_n = 0; lat = 0; seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (bus.busy) busy_n++;
            @(posedge clk); #1;
            if (bus.hilo_en) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        if (bus.busy) busy_n++;
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_hilo"}, bus.hilo_d, exp);
        check({tag, "_done"}, 64'(bus.done), 64'(1));
        check({tag, "_divzero"}, 64'(bus.div_zero), 64'(op[0] && b == 32'd0));
        @(posedge clk); #1;
        check({tag, "_en_low"}, 64'(bus.hilo_en), 64'(0));
        check({tag, "_busy_cycles"}, 64'(busy_n + int'(bus.busy)), 64'(W + 2));
        check({tag, "_hold"}, bus.hilo_d, exp);
    endtask

    initial begin
        int          wr0;
        bit          seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        n_checks = 0; n_pass = 0; n_wr = 0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;

        clr = 1'b1;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_en", 64'(bus.hilo_en), 64'(0));
        check("rst_divzero", 64'(bus.div_zero), 64'(0));
        check("rst_hilo", bus.hilo_d, 64'(0));
        clr = 1'b0;
        @(posedge clk); #1;

        run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulu_max_const", bus.hilo_d, 64'hFFFF_FFFE_0000_0001);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        check("divu_100_7_const", bus.hilo_d, {32'd2, 32'd14});
        run_op("divu_zero", 2'b01, 32'h1234_5678, 32'd0);
        check("divu_zero_const", bus.hilo_d, {32'h1234_5678, 32'hFFFF_FFFF});
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
        check("div_m7_2_const", bus.hilo_d, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        check("div_m7_2_const", bus.hilo_d, {32'd1, 32'h7FFF_FFFC});
`endif
        run_op("mul_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_sgn_zero", 2'b11, 32'hFFFF_FFF0, 32'd0);

        for (int k = 0; k < 24; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d", k), rop, ra, rb);
        end

        // Extra starts mid-op and during WB must be ignored.
        wr0 = n_wr;
        bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 32'd9; bus.b = 32'd9;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            bus.start = (i == 5);
            @(posedge clk); #1;
            if (bus.hilo_en) seen = 1'b1;
        end
        check("b2b_seen", 64'(seen), 64'(1));
        check("b2b_result", bus.hilo_d, 64'd42);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_wb_start_ignored", 64'(bus.busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        check("b2b_not_queued", 64'(bus.busy), 64'(0));
        check("b2b_one_write", 64'(n_wr - wr0), 64'(1));

        // Abort with clr mid-calculation.
        wr0 = n_wr;
        bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_en", 64'(bus.hilo_en), 64'(0));
        check("abort_divzero", 64'(bus.div_zero), 64'(0));
        check("abort_hilo", bus.hilo_d, 64'(0));
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_write", 64'(n_wr - wr0), 64'(0));
        check("abort_idle", 64'(bus.busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
